// File: rtl/uart_frame_loader.sv
// Command-tagged frame parser between uart_rx and the cipher/stream core (KEY, DATA, END frames).
// Optional inter-byte timeout abort is enabled by defining LOADER_TIMEOUT_EN.
module uart_frame_loader #(
  parameter int KEY_BYTES   = 8,
  parameter int LEN_BYTES   = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_err,
  input  logic                   data_full,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic                   mode_out,
  output logic                   key_en,
  output logic [7:0]             data_out,
  output logic                   data_en,
  output logic                   frame_end,
  output logic                   stream_end,
  output logic [7:0]             err_cnt,
  output logic [15:0]            drop_cnt,
  output logic [2:0]             state_out
);

  localparam int KW = 8*KEY_BYTES;
  localparam int LW = 8*LEN_BYTES;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KEY  = 3'd1,
    MODE = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4
  } state_t;

  state_t        state;
  logic [KW-1:0] shadow;
  logic [LW-1:0] n_rem;
  logic [LW-1:0] n_shift;
  logic [5:0]    cnt;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0]   tmo_cnt;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign n_shift   = LW'({n_rem, rx_data});
  assign state_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      n_rem      <= '0;
      cnt        <= '0;
      key_out    <= '0;
      mode_out   <= 1'b0;
      key_en     <= 1'b0;
      data_out   <= '0;
      data_en    <= 1'b0;
      frame_end  <= 1'b0;
      stream_end <= 1'b0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      key_en    <= 1'b0;
      data_en   <= 1'b0;
      frame_end <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      if (state == IDLE || rx_valid || rx_parity_err) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + 32'd1;
`endif
      // A parity error always wins over a byte arriving in the same cycle.
      if (rx_parity_err) begin
        err_cnt <= sat_inc8(err_cnt);
        state   <= IDLE;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            case (rx_data)
              8'h4B: begin state <= KEY; cnt <= '0; end
              8'h44: begin state <= LEN; cnt <= '0; n_rem <= '0; end
              8'h45: stream_end <= 1'b1;
              default: err_cnt <= sat_inc8(err_cnt);
            endcase
          end
          KEY: begin
            shadow <= KW'({shadow, rx_data});
            if (cnt == 6'(KEY_BYTES-1)) state <= MODE;
            else                        cnt   <= cnt + 6'd1;
          end
          MODE: begin
            key_out  <= shadow;
            mode_out <= rx_data[0];
            key_en   <= 1'b1;
            state    <= IDLE;
          end
          LEN: begin
            n_rem <= n_shift;
            if (cnt == 6'(LEN_BYTES-1)) begin
              if (n_shift == '0) begin
                frame_end <= 1'b1;
                state     <= IDLE;
              end else begin
                state <= DATA;
              end
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          DATA: begin
            n_rem <= n_rem - LW'(1);
            if (data_full) begin
              drop_cnt <= sat_inc16(drop_cnt);
            end else begin
              data_out <= rx_data;
              data_en  <= 1'b1;
            end
            if (n_rem == LW'(1)) begin
              frame_end <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef LOADER_TIMEOUT_EN
      else if (state != IDLE && tmo_cnt == 32'(TIMEOUT_CYC-1)) begin
        err_cnt <= sat_inc8(err_cnt);
        state   <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: frame-level reference model with randomized frames.
module tb_uart_frame_loader;

  localparam int KB = 8;
  localparam int LB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_parity_err = 1'b0;
  logic          data_full = 1'b0;
  logic [8*KB-1:0] key_out;
  logic          mode_out, key_en, data_en, frame_end, stream_end;
  logic [7:0]    data_out, err_cnt;
  logic [15:0]   drop_cnt;
  logic [2:0]    state_out;

  uart_frame_loader #(.KEY_BYTES(KB), .LEN_BYTES(LB), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .data_full(data_full), .key_out(key_out),
    .mode_out(mode_out), .key_en(key_en), .data_out(data_out), .data_en(data_en),
    .frame_end(frame_end), .stream_end(stream_end), .err_cnt(err_cnt),
    .drop_cnt(drop_cnt), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed strobes
  logic [7:0] got_q[$];
  int n_key_en = 0, n_data_en = 0, n_fe = 0, n_fe_de = 0;

  // Expected state, derived from the frames sent
  logic [7:0]    exp_q[$];
  logic [63:0]   exp_key = '0;
  logic          exp_mode = 1'b0;
  logic          exp_se = 1'b0;
  int exp_err = 0, exp_drop = 0, exp_fe = 0, exp_key_en = 0;

  always @(posedge clk) begin
    #1;
    if (data_en) begin got_q.push_back(data_out); n_data_en++; end
    if (key_en) n_key_en++;
    if (frame_end) begin n_fe++; if (data_en) n_fe_de++; end
  end

  task automatic send_byte(input logic [7:0] b, input logic full, input logic perr, input logic vld);
    rx_data = b; rx_valid = vld; data_full = full; rx_parity_err = perr;
    @(negedge clk);
    rx_valid = 1'b0; rx_parity_err = 1'b0; data_full = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] k, input logic m);
    logic [7:0] mb;
    send_byte(8'h4B, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < KB; i++) send_byte(k[63-8*i -: 8], 1'b0, 1'b0, 1'b1);
    mb = 8'($urandom);
    mb[0] = m;
    send_byte(mb, 1'b0, 1'b0, 1'b1);
    exp_key = k; exp_mode = m; exp_key_en++;
  endtask

  task automatic send_rand_data(input int len, input int full_pct);
    logic [7:0] b;
    logic f;
    logic [15:0] l16;
    l16 = 16'(len);
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    send_byte(l16[15:8], 1'b0, 1'b0, 1'b1);
    send_byte(l16[7:0], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      f = ($urandom_range(0, 99) < full_pct);
      send_byte(b, f, 1'b0, 1'b1);
      if (f) exp_drop++; else exp_q.push_back(b);
    end
    exp_fe++;
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_queue(input string name);
    logic bad;
    bad = (got_q.size() != exp_q.size());
    if (!bad) for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got %0d bytes %p, expected %0d bytes %p", name, got_q.size(), got_q, exp_q.size(), exp_q);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (key_out !== '0)    begin errors++; $display("FAIL reset_key: got %h expected 0", key_out); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if ({mode_out, key_en, data_en, frame_end, stream_end, err_cnt, drop_cnt} !== '0)
      begin errors++; $display("FAIL reset_outputs: got %b expected all 0", {mode_out, key_en, data_en, frame_end, stream_end, err_cnt, drop_cnt}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key_load();
    int k0;
    k0 = n_key_en;
    send_key(64'h0123456789ABCDEF, 1'b1);
    checks++; if (n_key_en - k0 !== 1) begin errors++; $display("FAIL key_en_count: got %0d expected 1", n_key_en - k0); end
    checks++; if (key_out !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL key_value: got %h expected 0123456789abcdef", key_out); end
    checks++; if (mode_out !== 1'b1) begin errors++; $display("FAIL key_mode: got %b expected 1", mode_out); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL key_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_data_full();
    int fd0;
    clear_queues();
    fd0 = n_fe_de;
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, 1'b1, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h33);
    exp_drop++; exp_fe++;
    check_queue("full_data");
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL full_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    checks++; if (n_fe_de - fd0 !== 1) begin errors++; $display("FAIL full_fe_with_strobe: got %0d expected 1", n_fe_de - fd0); end
    checks++; if (n_fe !== exp_fe) begin errors++; $display("FAIL full_fe_count: got %0d expected %0d", n_fe, exp_fe); end
  endtask

  task automatic test_rekey_zero();
    logic [63:0] ka, kbv;
    logic mb;
    int d0;
    ka = {$urandom, $urandom}; kbv = {$urandom, $urandom}; mb = 1'($urandom);
    d0 = n_data_en;
    send_key(ka, ~mb);
    send_key(kbv, mb);
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    exp_fe++;
    checks++; if (n_key_en !== exp_key_en) begin errors++; $display("FAIL rekey_count: got %0d expected %0d", n_key_en, exp_key_en); end
    checks++; if (key_out !== exp_key || mode_out !== exp_mode) begin errors++; $display("FAIL rekey_value: got %h/%b expected %h/%b", key_out, mode_out, exp_key, exp_mode); end
    checks++; if (n_fe !== exp_fe || n_data_en !== d0) begin errors++; $display("FAIL zero_len: got fe=%0d de=%0d expected fe=%0d de=%0d", n_fe, n_data_en, exp_fe, d0); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL zero_len_state: got %0d expected 0", state_out); end
  endtask

  task automatic test_parity_abort();
    int k0;
    k0 = n_key_en;
    clear_queues();
    send_byte(8'h4B, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
    send_byte(8'hAA, 1'b0, 1'b1, 1'b1);
    exp_err++;
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL parity_state: got %0d expected 0", state_out); end
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL parity_err: got %0d expected %0d", err_cnt, exp_err); end
    checks++; if (key_out !== exp_key || n_key_en !== k0) begin errors++; $display("FAIL parity_key: got %h expected %h", key_out, exp_key); end
    checks++; if (stream_end !== 1'b0) begin errors++; $display("FAIL se_before: got %b expected 0", stream_end); end
    send_byte(8'h45, 1'b0, 1'b0, 1'b1);
    exp_se = 1'b1;
    checks++; if (stream_end !== 1'b1) begin errors++; $display("FAIL se_set: got %b expected 1", stream_end); end
    send_byte(8'h00, 1'b0, 1'b1, 1'b0);
    exp_err++;
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'h05, 1'b0, 1'b0, 1'b1);
    send_byte(8'h4B, 1'b0, 1'b0, 1'b1); exp_q.push_back(8'h4B);
    send_byte(8'h45, 1'b0, 1'b0, 1'b1); exp_q.push_back(8'h45);
    send_byte(8'h00, 1'b0, 1'b1, 1'b0);
    exp_err++;
    check_queue("parity_data_kept");
    checks++; if (n_fe !== exp_fe || err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL parity_data: got fe=%0d err=%0d expected fe=%0d err=%0d", n_fe, err_cnt, exp_fe, exp_err); end
  endtask

  task automatic test_random_frames();
    clear_queues();
    for (int f = 0; f < 16; f++) begin
      case ($urandom_range(0, 3))
        0: send_key({$urandom, $urandom}, 1'($urandom));
        1: begin send_byte(8'h45, 1'b0, 1'b0, 1'b1); exp_se = 1'b1; end
        default: send_rand_data($urandom_range(0, 6), 30);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_queue("rand_data");
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    checks++; if (n_fe !== exp_fe || n_key_en !== exp_key_en) begin errors++; $display("FAIL rand_pulses: got fe=%0d ke=%0d expected fe=%0d ke=%0d", n_fe, n_key_en, exp_fe, exp_key_en); end
    checks++; if (key_out !== exp_key || mode_out !== exp_mode) begin errors++; $display("FAIL rand_key: got %h/%b expected %h/%b", key_out, mode_out, exp_key, exp_mode); end
    checks++; if (err_cnt !== 8'(exp_err) || stream_end !== exp_se) begin errors++; $display("FAIL rand_status: got err=%0d se=%b expected err=%0d se=%b", err_cnt, stream_end, exp_err, exp_se); end
  endtask

  task automatic test_timeout();
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
`ifdef LOADER_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 101 && !seen; i++) begin
        if (state_out == 3'd0) seen = 1'b1;
        else @(negedge clk);
      end
      exp_err++;
      checks++; if (!seen) begin errors++; $display("FAIL timeout_abort: got state %0d expected 0 within 101 cycles", state_out); end
      checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL timeout_err: got %0d expected %0d", err_cnt, exp_err); end
    end
`else
    repeat (150) @(negedge clk);
    checks++; if (state_out !== 3'd3) begin errors++; $display("FAIL no_timeout_state: got %0d expected 3", state_out); end
    send_byte(8'h00, 1'b0, 1'b1, 1'b0);
    exp_err++;
    checks++; if (state_out !== 3'd0 || err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL no_timeout_abort: got state=%0d err=%0d expected 0/%0d", state_out, err_cnt, exp_err); end
`endif
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL err_saturate: got %0d expected %0d", err_cnt, exp_err); end
    for (int i = 0; i < 5; i++) send_byte(8'h13, 1'b0, 1'b0, 1'b1);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_hold: got %0d expected 255", err_cnt); end
  endtask

  task automatic test_async_reset();
    send_byte(8'h4B, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (key_out !== '0 || state_out !== 3'd0 || err_cnt !== 8'd0 || stream_end !== 1'b0)
      begin errors++; $display("FAIL async_reset: got key=%h st=%0d err=%0d se=%b expected all 0", key_out, state_out, err_cnt, stream_end); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_key = '0; exp_mode = 1'b0; exp_err = 0; exp_drop = 0; exp_se = 1'b0;
    @(negedge clk);
    send_byte(8'h45, 1'b0, 1'b0, 1'b1);
    checks++; if (stream_end !== 1'b1 || err_cnt !== 8'd0 || state_out !== 3'd0)
      begin errors++; $display("FAIL post_reset_cmd: got se=%b err=%0d st=%0d expected 1/0/0", stream_end, err_cnt, state_out); end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_data_full();
    test_rekey_zero();
    test_parity_abort();
    test_random_frames();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
